// File: rtl/issue_cdb_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// issue_cdb_scheduler : single-issue rotating-priority scheduler that
// reserves the CDB broadcast slot of every issued op. Rev 1.0
// ---------------------------------------------------------------------------
module issue_cdb_scheduler #(
    parameter int INT_LAT  = 1,
    parameter int LDSW_LAT = 2,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_empty,
    input  logic       ld_sw_empty,
    input  logic       mult_empty,
    input  logic       div_empty,
    output logic       int_rd,
    output logic       ld_sw_rd,
    output logic       mult_rd,
    output logic       div_rd,
    output logic [1:0] cdb_sel,
    output logic       cdb_sel_valid,
    output logic       div_busy
);

    localparam int MAXL = 7;

    logic [MAXL:0] r_rsv;
    logic [1:0]    r_own [0:MAXL];
    logic [1:0]    r_rr_ptr;
    logic [1:0]    r_last_sel;
    logic [2:0]    r_div_cnt;

    logic [3:0]    w_elig;
    logic [3:0]    w_grant;
    logic [1:0]    w_idx;
    logic          w_found;

    // A unit may issue only if the CDB slot it would broadcast in is still free.
    always_comb begin
        w_elig[0] = !int_empty   && !r_rsv[INT_LAT];
        w_elig[1] = !ld_sw_empty && !r_rsv[LDSW_LAT];
        w_elig[2] = !mult_empty  && !r_rsv[MULT_LAT];
        w_elig[3] = !div_empty   && !r_rsv[DIV_LAT] && (r_div_cnt == 3'd0);
    end

    always_comb begin
        w_grant = 4'b0000;
        w_found = 1'b0;
        w_idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_rr_ptr + 2'(i);
            if (!w_found && w_elig[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign int_rd   = w_grant[0] & rst_n;
    assign ld_sw_rd = w_grant[1] & rst_n;
    assign mult_rd  = w_grant[2] & rst_n;
    assign div_rd   = w_grant[3] & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsv      <= '0;
            for (int k = 0; k <= MAXL; k++) begin
                r_own[k] <= 2'd0;
            end
            r_rr_ptr   <= 2'd3;
            r_last_sel <= 2'd0;
            r_div_cnt  <= 3'd0;
        end else begin
            for (int k = 0; k < MAXL; k++) begin
                r_rsv[k] <= r_rsv[k+1];
                r_own[k] <= r_own[k+1];
            end
            r_rsv[MAXL] <= 1'b0;
            r_own[MAXL] <= 2'd0;

            // Slot L-1 after the shift is the slot L cycles from the grant cycle.
            if (w_grant[0]) begin
                r_rsv[INT_LAT-1] <= 1'b1;
                r_own[INT_LAT-1] <= 2'd0;
                r_rr_ptr         <= 2'd0;
            end
            if (w_grant[1]) begin
                r_rsv[LDSW_LAT-1] <= 1'b1;
                r_own[LDSW_LAT-1] <= 2'd1;
                r_rr_ptr          <= 2'd1;
            end
            if (w_grant[2]) begin
                r_rsv[MULT_LAT-1] <= 1'b1;
                r_own[MULT_LAT-1] <= 2'd2;
                r_rr_ptr          <= 2'd2;
            end
            if (w_grant[3]) begin
                r_rsv[DIV_LAT-1] <= 1'b1;
                r_own[DIV_LAT-1] <= 2'd3;
                r_rr_ptr         <= 2'd3;
            end

            if (r_rsv[0]) begin
                r_last_sel <= r_own[0];
            end

            if (w_grant[3]) begin
                r_div_cnt <= 3'(DIV_LAT - 1);
            end else if (r_div_cnt != 3'd0) begin
                r_div_cnt <= r_div_cnt - 3'd1;
            end
        end
    end

    assign cdb_sel_valid = r_rsv[0];
    assign cdb_sel       = r_rsv[0] ? r_own[0] : r_last_sel;
    assign div_busy      = (r_div_cnt != 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_issue_cdb_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_issue_cdb_scheduler : directed self-checking bench for the scheduler.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_issue_cdb_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       int_empty, ld_sw_empty, mult_empty, div_empty;
    logic       int_rd, ld_sw_rd, mult_rd, div_rd;
    logic [1:0] cdb_sel;
    logic       cdb_sel_valid;
    logic       div_busy;
    logic [3:0] rd;

    int checks = 0;
    int errors = 0;

    issue_cdb_scheduler #(
        .INT_LAT (1),
        .LDSW_LAT(2),
        .MULT_LAT(4),
        .DIV_LAT (6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .int_empty    (int_empty),
        .ld_sw_empty  (ld_sw_empty),
        .mult_empty   (mult_empty),
        .div_empty    (div_empty),
        .int_rd       (int_rd),
        .ld_sw_rd     (ld_sw_rd),
        .mult_rd      (mult_rd),
        .div_rd       (div_rd),
        .cdb_sel      (cdb_sel),
        .cdb_sel_valid(cdb_sel_valid),
        .div_busy     (div_busy)
    );

    always #5 clk = ~clk;

    assign rd = {div_rd, mult_rd, ld_sw_rd, int_rd};

    // Bit order {div, mult, ld/sw, int}; a 1 means that FIFO is empty.
    task automatic set_empty(input logic [3:0] e);
        int_empty   = e[0];
        ld_sw_empty = e[1];
        mult_empty  = e[2];
        div_empty   = e[3];
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_empty(4'b1111);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_empty(4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd !== 4'b0000) begin
            errors++;
            $display("FAIL reset_rd got %b want 0000", rd);
        end
        checks++;
        if ({cdb_sel_valid, cdb_sel, div_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outs got v=%b sel=%0d busy=%b want 0/0/0",
                     cdb_sel_valid, cdb_sel, div_busy);
        end
        set_empty(4'b1111);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({rd, cdb_sel_valid, cdb_sel, div_busy} !== 8'h00) begin
            errors++;
            $display("FAIL post_reset got rd=%b v=%b sel=%0d busy=%b want all 0",
                     rd, cdb_sel_valid, cdb_sel, div_busy);
        end
        next_cycle();
    endtask

    task automatic test_int_only();
        do_reset();
        for (int t = 0; t <= 4; t++) begin
            set_empty((t < 3) ? 4'b1110 : 4'b1111);
            @(negedge clk);
            checks++;
            if (rd !== ((t < 3) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL int_only_rd t=%0d got %b want %b", t, rd,
                         (t < 3) ? 4'b0001 : 4'b0000);
            end
            checks++;
            if (cdb_sel_valid !== (t >= 1 && t <= 3) || cdb_sel !== 2'd0) begin
                errors++;
                $display("FAIL int_only_cdb t=%0d got v=%b sel=%0d want v=%b sel=0",
                         t, cdb_sel_valid, cdb_sel, (t >= 1 && t <= 3));
            end
            next_cycle();
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_rd  [0:10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                       4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                       4'b0000};
        logic       exp_v   [0:10] = '{0, 1, 0, 1, 0, 1, 1, 0, 0, 1, 0};
        logic [1:0] exp_sel [0:10] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0,
                                       2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
        do_reset();
        for (int t = 0; t <= 10; t++) begin
            set_empty((t <= 4) ? 4'b0000 : 4'b1111);
            @(negedge clk);
            checks++;
            if (rd !== exp_rd[t]) begin
                errors++;
                $display("FAIL rotation_rd t=%0d got %b want %b", t, rd, exp_rd[t]);
            end
            checks++;
            if (cdb_sel_valid !== exp_v[t] || cdb_sel !== exp_sel[t]) begin
                errors++;
                $display("FAIL rotation_cdb t=%0d got v=%b sel=%0d want v=%b sel=%0d",
                         t, cdb_sel_valid, cdb_sel, exp_v[t], exp_sel[t]);
            end
            next_cycle();
        end
    endtask

    task automatic test_slot_collision();
        logic [3:0] empt    [0:6] = '{4'b1011, 4'b1111, 4'b1101, 4'b1100,
                                      4'b1111, 4'b1111, 4'b1111};
        logic [3:0] exp_rd  [0:6] = '{4'b0100, 4'b0000, 4'b0000, 4'b0010,
                                      4'b0000, 4'b0000, 4'b0000};
        logic       exp_v   [0:6] = '{0, 0, 0, 0, 1, 1, 0};
        logic [1:0] exp_sel [0:6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd1};
        do_reset();
        for (int t = 0; t <= 6; t++) begin
            set_empty(empt[t]);
            @(negedge clk);
            checks++;
            if (rd !== exp_rd[t]) begin
                errors++;
                $display("FAIL collision_rd t=%0d got %b want %b", t, rd, exp_rd[t]);
            end
            checks++;
            if (cdb_sel_valid !== exp_v[t] || cdb_sel !== exp_sel[t]) begin
                errors++;
                $display("FAIL collision_cdb t=%0d got v=%b sel=%0d want v=%b sel=%0d",
                         t, cdb_sel_valid, cdb_sel, exp_v[t], exp_sel[t]);
            end
            next_cycle();
        end
    endtask

    task automatic test_div_busy();
        logic [3:0] erd;
        logic       ebusy;
        logic       ev;
        do_reset();
        for (int t = 0; t <= 12; t++) begin
            set_empty(4'b0111);
            erd   = (t % 6 == 0) ? 4'b1000 : 4'b0000;
            ebusy = (t % 6 != 0);
            ev    = (t == 6 || t == 12);
            @(negedge clk);
            checks++;
            if (rd !== erd || div_busy !== ebusy) begin
                errors++;
                $display("FAIL div_busy t=%0d got rd=%b busy=%b want rd=%b busy=%b",
                         t, rd, div_busy, erd, ebusy);
            end
            checks++;
            if (cdb_sel_valid !== ev || (ev && cdb_sel !== 2'd3)) begin
                errors++;
                $display("FAIL div_cdb t=%0d got v=%b sel=%0d want v=%b sel=3",
                         t, cdb_sel_valid, cdb_sel, ev);
            end
            next_cycle();
        end
        set_empty(4'b1111);
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_empty(4'b1011);
        @(negedge clk);
        checks++;
        if (rd !== 4'b0100) begin
            errors++;
            $display("FAIL mid_mult_grant got %b want 0100", rd);
        end
        next_cycle();
        set_empty(4'b0111);
        @(negedge clk);
        checks++;
        if (rd !== 4'b1000) begin
            errors++;
            $display("FAIL mid_div_grant got %b want 1000", rd);
        end
        next_cycle();
        rst_n = 1'b0;
        set_empty(4'b0000);
        @(negedge clk);
        checks++;
        if (rd !== 4'b0000 || div_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_in_reset got rd=%b busy=%b want 0000/0", rd, div_busy);
        end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cdb_sel_valid !== 1'b0 || div_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_dropped got v=%b busy=%b want 0/0", cdb_sel_valid, div_busy);
        end
        checks++;
        if (rd !== 4'b0001) begin
            errors++;
            $display("FAIL mid_first_grant got %b want 0001", rd);
        end
        next_cycle();
        set_empty(4'b1111);
        repeat (8) next_cycle();
    endtask

    task automatic test_empty_boundary();
        do_reset();
        set_empty(4'b1101);
        @(negedge clk);
        checks++;
        if (rd !== 4'b0010) begin
            errors++;
            $display("FAIL empty_seed got %b want 0010", rd);
        end
        next_cycle();
        set_empty(4'b1111);
        repeat (3) next_cycle();
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            checks++;
            if (rd !== 4'b0000 || cdb_sel_valid !== 1'b0 || cdb_sel !== 2'd1) begin
                errors++;
                $display("FAIL empty_idle t=%0d got rd=%b v=%b sel=%0d want 0000/0/1",
                         t, rd, cdb_sel_valid, cdb_sel);
            end
            next_cycle();
        end
        set_empty(4'b0000);
        @(negedge clk);
        checks++;
        if (rd !== 4'b0100) begin
            errors++;
            $display("FAIL empty_resume got %b want 0100", rd);
        end
        next_cycle();
        set_empty(4'b1111);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_empty(4'b1111);
        test_reset();
        test_int_only();
        test_rotation();
        test_slot_collision();
        test_div_busy();
        test_reset_mid();
        test_empty_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_cdb_scheduler.md
# issue_cdb_scheduler

Single-issue scheduler between the dispatcher's four execution FIFOs (int, ld/sw, mult, div) and the execution units. Each cycle it pops at most one FIFO, using rotating priority among the FIFOs that can issue. It reserves the common data bus (CDB) slot in which the issued instruction will broadcast, so no two units ever drive the CDB in the same cycle. It also drives the CDB source-select mux and tracks the non-pipelined divider.

## Interface
Parameters:
- INT_LAT, 1, cycles from int issue to CDB broadcast
- LDSW_LAT, 2, cycles from ld/sw issue to CDB broadcast
- MULT_LAT, 4, cycles from mult issue to broadcast (pipelined unit)
- DIV_LAT, 6, cycles from div issue to broadcast; the divider is non-pipelined
- All latencies must lie in 1..7; the reservation depth MAXL is 7

Ports:
- clk, in, 1, single clock
- rst_n, in, 1, asynchronous active-low reset
- int_empty, in, 1, int exec FIFO empty
- ld_sw_empty, in, 1, ld/sw exec FIFO empty
- mult_empty, in, 1, mult exec FIFO empty
- div_empty, in, 1, div exec FIFO empty
- int_rd, out, 1, pop int FIFO; the unit samples data_out this cycle
- ld_sw_rd, out, 1, pop ld/sw FIFO
- mult_rd, out, 1, pop mult FIFO
- div_rd, out, 1, pop div FIFO
- cdb_sel, out, 2, unit owning the CDB this cycle: 0 int, 1 ld/sw, 2 mult, 3 div
- cdb_sel_valid, out, 1, a reserved broadcast occurs this cycle
- div_busy, out, 1, divider occupied

## Operation
- State:
  - rsv[0..MAXL]: reservation bits; rsv[k]=1 means the CDB slot k cycles from now is taken.
  - own[0..MAXL]: 2-bit unit tag per slot.
  - rr_ptr: 2 bits, last granted unit.
  - div_cnt: 3 bits.
- Eligibility of unit u with latency L: its FIFO is not empty AND rsv[L]==0. The div unit additionally requires div_cnt==0.
- Grant: one-hot over the eligible units. The search order starts at rr_ptr+1 mod 4 and ascends with wrap. No eligible unit means no grant. The *_rd output equals the grant (combinational).
- Update on each clk edge:
  - Shift: rsv[k]<=rsv[k+1] and own[k]<=own[k+1] for k<MAXL; rsv[MAXL]<=0.
  - On a grant of unit u with latency L: rsv[L-1]<=1, own[L-1]<=u, rr_ptr<=u.
- Outputs: cdb_sel_valid=rsv[0] and cdb_sel=own[0]. When rsv[0]==0, cdb_sel holds its last value.
- Divider tracking:
  - On div grant: div_cnt<=DIV_LAT-1.
  - Otherwise, if div_cnt!=0: div_cnt<=div_cnt-1.
  - div_busy=(div_cnt!=0).
- Collision rules:
  - Two grants in one cycle are impossible because issue is one-hot.
  - Grants in different cycles targeting the same slot are blocked by the rsv[L] check.
  - A blocked unit retries every cycle with no starvation: its rsv[L] slot frees within MAXL cycles, and rotation guarantees service within 4 grants.
- Reset, asynchronous, including mid-operation: rsv, own, div_cnt=0 and rr_ptr=3, which makes int the first priority. In-flight reservations are discarded. All *_rd are forced to 0 while rst_n==0.

## Timing
- Unit issued at cycle t broadcasts with cdb_sel_valid=1 and cdb_sel=u at cycle t+L exactly.
- Pop-to-grant latency is 0 cycles; the FIFO data is consumed in the grant cycle.
- Throughput is at most 1 issue per cycle and at most 1 CDB broadcast per cycle.
- The divider accepts a new op no earlier than t+DIV_LAT after a div grant at t.
- Reset values: int_rd=ld_sw_rd=mult_rd=div_rd=0, cdb_sel=0, cdb_sel_valid=0, div_busy=0.
- FIFO empty inputs are used the same cycle. The FIFO must deassert empty no later than the cycle its data is valid.

## Test plan
- **Reset, then int-only:** after rst_n rises, int_empty=0 for 3 cycles at t0..t2, others empty -> int_rd=1 at t0..t2; cdb_sel_valid=1, cdb_sel=0 at t1..t3; no other *_rd.
- **Rotation:** all four FIFOs non-empty from t0 -> grants int t0, ld/sw t1, mult t2, div t3, int t4; CDB owners int t1, ld/sw t3, mult t6, div t9.
- **Slot collision:** mult granted at t0 reserves t4; at t2 only ld/sw is non-empty -> ld_sw_rd=0 at t2 because its slot t4 is taken, then ld_sw_rd=1 at t3, broadcasting at t5; at t3 int would target t4 and must also be blocked.
- **Divider busy:** div_empty=0 continuously with a div grant at t0 -> div_busy=1 t1..t5, div_rd=0 t1..t5, next div_rd=1 at t6, broadcasts at t6 and t12.
- **Reset mid-operation:** mult granted at t0, rst_n low at t2 for 2 cycles -> at t4 cdb_sel_valid=0 (reservation dropped), div_busy=0, and the first grant after reset goes to int when int is non-empty.
- **Empty boundary:** all FIFOs empty for 10 cycles after in-flight ops drain -> every *_rd=0, cdb_sel_valid=0, and rr_ptr unchanged, so the next grant follows the last grantee.
